// File: rtl/tty_uart_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tty_uart_bridge_if                                      |
// | Purpose  : Teletype register port between the UART bridge and the  |
// |            teletype device model/registers.                        |
// | Ports    : ttwrite  - one-cycle write strobe                       |
// |            ttraddr  - read register select (2 bits)                |
// |            ttwaddr  - write register select (2 bits)               |
// |            ttwdata  - write data (32 bits)                         |
// |            ttrdata  - read data, combinational from ttraddr        |
// | Modports : master (bridge side), slave (teletype side)             |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface tty_uart_bridge_if;
  logic        ttwrite;
  logic [1:0]  ttraddr;
  logic [1:0]  ttwaddr;
  logic [31:0] ttwdata;
  logic [31:0] ttrdata;

  modport master (
    output ttwrite,
    output ttraddr,
    output ttwaddr,
    output ttwdata,
    input  ttrdata
  );

  modport slave (
    input  ttwrite,
    input  ttraddr,
    input  ttwaddr,
    input  ttwdata,
    output ttrdata
  );
endinterface
`default_nettype wire

// File: rtl/tty_uart_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tty_uart_bridge                                         |
// | Purpose  : Bridges an 8N1 serial line to a memory-mapped teletype. |
// |            Received bytes are delivered to teletype register 1     |
// |            (keyboard); characters flagged in register 2 (printer)  |
// |            are shifted out on txd and acknowledged.                |
// | Params   : BAUDDIV - CLOCK cycles per 16x oversample tick          |
// |            ENABLE  - enable bit value for keyboard writes          |
// | Ports    : CLOCK   - system clock, rising edge                     |
// |            RESET   - synchronous, active-high reset                |
// |            rxd     - async serial input, idle high                 |
// |            txd     - registered serial output, idle high           |
// |            overrun - saturating dropped-byte count (holding full)  |
// |            framerr - saturating bad-stop-bit count                 |
// |            tt      - teletype register port (master)               |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tty_uart_bridge #(
  parameter int   BAUDDIV = 651,
  parameter logic ENABLE  = 1'b1
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    rxd,
  output logic                    txd,
  output logic [7:0]              overrun,
  output logic [7:0]              framerr,
  tty_uart_bridge_if.master       tt
);

  // ------------------------------------------------------------------
  // 16x oversample tick generator (free-running)
  // ------------------------------------------------------------------
  localparam int             TICK_W    = (BAUDDIV > 1) ? $clog2(BAUDDIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUDDIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // rxd synchronizer; reset to the idle (high) level
  // ------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t  rx_state, rx_next;
  logic [3:0] rx_cnt,   rx_cnt_next;
  logic [2:0] rx_bit,   rx_bit_next;
  logic [7:0] rx_shift, rx_shift_next;
  logic       byte_done;
  logic       frame_bad;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_next;
      rx_bit   <= rx_bit_next;
      rx_shift <= rx_shift_next;
    end
  end

  always_comb begin
    rx_next       = rx_state;
    rx_cnt_next   = rx_cnt;
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    byte_done     = 1'b0;
    frame_bad     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_next     = RX_START;
          rx_cnt_next = '0;
        end
      end
      RX_START: begin
        // Eight ticks lands near the middle of the start bit; a line that
        // has gone high again by then was a glitch.
        if (tick) begin
          if (rx_cnt == 4'd7) begin
            rx_cnt_next = '0;
            rx_bit_next = '0;
            rx_next     = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_next = rx_cnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_cnt_next = rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) begin
            rx_shift_next = {rx_sync, rx_shift[7:1]};
            rx_bit_next   = rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
              rx_next = RX_STOP;
            end
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_cnt_next = rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) begin
            rx_next = RX_IDLE;
            if (rx_sync) begin
              byte_done = 1'b1;
            end else begin
              frame_bad = 1'b1;
            end
          end
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  logic       tx_load;
  logic       tx_busy;
  logic       tx_started;
  logic [3:0] tx_cnt;
  logic [3:0] tx_bits;
  logic [9:0] tx_shift;

  // The first bit is launched on a tick so that every bit, including the
  // start bit, spans exactly sixteen full tick periods.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
      tx_started <= 1'b0;
      tx_cnt     <= '0;
      tx_bits    <= '0;
      tx_shift   <= '1;
    end else if (tx_load) begin
      tx_shift   <= {1'b1, tt.ttrdata[7:0], 1'b0};
      tx_busy    <= 1'b1;
      tx_started <= 1'b0;
      tx_cnt     <= '0;
      tx_bits    <= '0;
    end else if (tx_busy && tick) begin
      if (!tx_started) begin
        tx_started <= 1'b1;
        txd        <= tx_shift[0];
        tx_cnt     <= '0;
      end else if (tx_cnt == 4'd15) begin
        tx_cnt <= '0;
        if (tx_bits == 4'd9) begin
          tx_busy    <= 1'b0;
          tx_started <= 1'b0;
          txd        <= 1'b1;
        end else begin
          tx_bits  <= tx_bits + 4'd1;
          tx_shift <= {1'b1, tx_shift[9:1]};
          txd      <= tx_shift[1];
        end
      end else begin
        tx_cnt <= tx_cnt + 4'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Poll engine
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    POLLKB = 2'd0,
    POLLPR = 2'd1,
    TXWAIT = 2'd2,
    PRDONE = 2'd3
  } poll_state_t;

  poll_state_t poll_state, poll_next;
  logic        printing, printing_next;
  logic        kb_deliver;
  logic        kbfull;
  logic [7:0]  kbhold;

  logic        wr_en;
  logic [1:0]  rd_addr;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;

  assign tt.ttwrite = wr_en;
  assign tt.ttraddr = rd_addr;
  assign tt.ttwaddr = wr_addr;
  assign tt.ttwdata = wr_data;

  // Only the status flags and the character byte of the read data matter.
  logic unused_rdata_bits;
  assign unused_rdata_bits = ^tt.ttrdata[29:8];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      poll_state <= POLLKB;
      printing   <= 1'b0;
    end else begin
      poll_state <= poll_next;
      printing   <= printing_next;
    end
  end

  // While a character is printing, the engine ping-pongs between TXWAIT
  // and POLLKB so keyboard bytes keep flowing during the transmission.
  always_comb begin
    poll_next     = poll_state;
    printing_next = printing;
    wr_en         = 1'b0;
    rd_addr       = 2'd1;
    wr_addr       = 2'd0;
    wr_data       = 32'h0;
    kb_deliver    = 1'b0;
    tx_load       = 1'b0;
    case (poll_state)
      POLLKB: begin
        rd_addr = 2'd1;
        if (kbfull && !tt.ttrdata[31]) begin
          kb_deliver = 1'b1;
          wr_en      = 1'b1;
          wr_addr    = 2'd1;
          wr_data    = {1'b1, ENABLE, 18'b0, 4'b0, kbhold};
        end
        poll_next = printing ? TXWAIT : POLLPR;
      end
      POLLPR: begin
        rd_addr = 2'd2;
        if (tt.ttrdata[30] && !tx_busy) begin
          tx_load       = 1'b1;
          printing_next = 1'b1;
          poll_next     = TXWAIT;
        end else begin
          poll_next = POLLKB;
        end
      end
      TXWAIT: begin
        rd_addr = 2'd2;
        if (!tx_busy) begin
          printing_next = 1'b0;
          poll_next     = PRDONE;
        end else begin
          poll_next = POLLKB;
        end
      end
      PRDONE: begin
        rd_addr   = 2'd2;
        wr_en     = 1'b1;
        wr_addr   = 2'd2;
        wr_data   = {1'b1, 1'b0, 30'b0};
        poll_next = POLLKB;
      end
      default: poll_next = POLLKB;
    endcase
  end

  // ------------------------------------------------------------------
  // Keyboard holding register and error counters
  // ------------------------------------------------------------------
  // A byte completing in the same cycle the engine empties the holder is
  // accepted rather than counted as an overrun.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      kbfull  <= 1'b0;
      kbhold  <= '0;
      overrun <= '0;
    end else if (byte_done) begin
      if (!kbfull || kb_deliver) begin
        kbhold <= rx_shift;
        kbfull <= 1'b1;
      end else if (overrun != 8'hFF) begin
        overrun <= overrun + 8'd1;
      end
    end else if (kb_deliver) begin
      kbfull <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      framerr <= '0;
    end else if (frame_bad && (framerr != 8'hFF)) begin
      framerr <= framerr + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tty_uart_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_tty_uart_bridge                                      |
// | Purpose  : Directed self-checking bench for tty_uart_bridge with   |
// |            BAUDDIV=4 (one serial bit = 64 CLOCK cycles). Models    |
// |            teletype registers 1 (kbbusy in bit 31) and 2 (printer  |
// |            char, prfull cleared by the acknowledge write).         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_tty_uart_bridge;

  logic       CLOCK;
  logic       RESET;
  logic       rxd;
  logic       txd;
  logic [7:0] overrun;
  logic [7:0] framerr;

  tty_uart_bridge_if tt ();

  tty_uart_bridge #(
    .BAUDDIV (4),
    .ENABLE  (1'b1)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .rxd     (rxd),
    .txd     (txd),
    .overrun (overrun),
    .framerr (framerr),
    .tt      (tt)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Teletype register model
  logic [31:0] kb_reg;
  logic [31:0] pr_data;
  int          pr_base;

  // Write monitor
  int          n_wr1, n_wr2, n_wr_bad;
  logic [31:0] last_wr1, last_wr2;
  int          wr1_cyc, wr2_cyc, cyc;

  // Register 2 reads as pr_data until the bridge acknowledges it once.
  assign tt.ttrdata = (tt.ttraddr == 2'd1) ? kb_reg :
                      ((tt.ttraddr == 2'd2) && (n_wr2 == pr_base)) ? pr_data :
                      32'h0;

  initial begin
    n_wr1 = 0; n_wr2 = 0; n_wr_bad = 0;
    last_wr1 = '0; last_wr2 = '0;
    wr1_cyc = 0; wr2_cyc = 0; cyc = 0;
  end

  always @(negedge CLOCK) begin
    cyc <= cyc + 1;
    if (!RESET && tt.ttwrite) begin
      if (tt.ttwaddr == 2'd1) begin
        n_wr1    <= n_wr1 + 1;
        last_wr1 <= tt.ttwdata;
        wr1_cyc  <= cyc;
      end else if (tt.ttwaddr == 2'd2) begin
        n_wr2    <= n_wr2 + 1;
        last_wr2 <= tt.ttwdata;
        wr2_cyc  <= cyc;
      end else begin
        n_wr_bad <= n_wr_bad + 1;
      end
    end
  end

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    clocks(64);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      clocks(64);
    end
    if (stop) begin
      rxd = 1'b1;
      clocks(64);
    end else begin
      // Short bad stop bit so the trailing low cannot look like a new start.
      rxd = 1'b0;
      clocks(40);
      rxd = 1'b1;
      clocks(24);
    end
  endtask

  // Waits for a start bit, measures it, then samples bits 1..9 mid-bit.
  task automatic capture_frame(input string tag, output logic [9:0] frame,
                               output int start_len, output int n2_at_stop);
    int waited;
    waited     = 0;
    frame      = '1;
    start_len  = 0;
    n2_at_stop = -1;
    while ((txd !== 1'b0) && (waited < 3000)) begin
      @(negedge CLOCK);
      waited++;
    end
    check({tag, "_start_seen"}, {31'b0, txd}, 32'd0);
    frame[0] = txd;
    while ((txd === 1'b0) && (start_len < 200)) begin
      @(negedge CLOCK);
      start_len++;
    end
    clocks(32);
    for (int k = 1; k < 10; k++) begin
      frame[k] = txd;
      if (k == 9) n2_at_stop = n_wr2;
      if (k < 9) clocks(64);
    end
  endtask

  task automatic wait_wr2(input int target);
    int waited;
    waited = 0;
    while ((n_wr2 < target) && (waited < 200)) begin
      @(negedge CLOCK);
      waited++;
    end
  endtask

  logic [9:0] frame;
  int         slen, n2s, base;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET    = 1'b1;
    rxd      = 1'b1;
    kb_reg   = 32'h0;
    pr_data  = 32'h0;
    pr_base  = 0;
    clocks(5);

    // Reset state
    check("rst_txd",     {31'b0, txd},          32'd1);
    check("rst_ttwrite", {31'b0, tt.ttwrite},   32'd0);
    check("rst_ttraddr", {30'b0, tt.ttraddr},   32'd1);
    check("rst_ttwaddr", {30'b0, tt.ttwaddr},   32'd0);
    check("rst_ttwdata", tt.ttwdata,            32'h0);
    check("rst_overrun", {24'b0, overrun},      32'd0);
    check("rst_framerr", {24'b0, framerr},      32'd0);
    RESET = 1'b0;
    clocks(10);

    // Keyboard byte 0x41 delivered to register 1
    send_byte(8'h41, 1'b1);
    clocks(20);
    check("kb_wr_count", n_wr1,              32'd1);
    check("kb_wr_data",  last_wr1,           32'hC000_0041);
    check("kb_no_wr2",   n_wr2,              32'd0);
    check("kb_bad_addr", n_wr_bad,           32'd0);
    check("kb_emptied",  {31'b0, dut.kbfull}, 32'd0);

    // Bad stop bit
    send_byte(8'h55, 1'b0);
    clocks(100);
    check("fe_count",    {24'b0, framerr},    32'd1);
    check("fe_overrun",  {24'b0, overrun},    32'd0);
    check("fe_no_write", n_wr1,               32'd1);
    check("fe_kbfull",   {31'b0, dut.kbfull}, 32'd0);

    // Two-tick glitch
    rxd = 1'b0;
    clocks(8);
    rxd = 1'b1;
    clocks(200);
    check("gl_framerr",  {24'b0, framerr},    32'd1);
    check("gl_overrun",  {24'b0, overrun},    32'd0);
    check("gl_no_write", n_wr1,               32'd1);
    check("gl_kbfull",   {31'b0, dut.kbfull}, 32'd0);

    // Print 0x8D while a keyboard byte arrives concurrently
    base    = n_wr2;
    pr_base = n_wr2;
    pr_data = 32'h4000_008D;
    fork
      capture_frame("pr", frame, slen, n2s);
      send_byte(8'h5A, 1'b1);
    join
    check("pr_start_len", slen,            32'd64);
    check("pr_frame",     {22'b0, frame},  32'h31A);
    check("pr_no_early",  n2s,             base);
    wait_wr2(base + 1);
    check("pr_ack_count", n_wr2,           base + 1);
    check("pr_ack_data",  last_wr2,        32'h8000_0000);
    clocks(20);
    check("pr_kb_count",  n_wr1,           32'd2);
    check("pr_kb_data",   last_wr1,        32'hC000_005A);
    check("pr_kb_first",  {31'b0, (wr1_cyc < wr2_cyc)}, 32'd1);
    check("pr_ack_once",  n_wr2,           base + 1);

    // Overrun: keyboard busy, three bytes back to back
    kb_reg = 32'h8000_0000;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    clocks(20);
    check("ov_count",    {24'b0, overrun},    32'd2);
    check("ov_no_write", n_wr1,               32'd2);
    check("ov_held",     {24'b0, dut.kbhold}, 32'h11);
    kb_reg = 32'h0;
    clocks(10);
    check("ov_release_count", n_wr1,               32'd3);
    check("ov_release_data",  last_wr1,            32'hC000_0011);
    check("ov_release_empty", {31'b0, dut.kbfull}, 32'd0);

    // Reset during TX data bit 3, then retransmission
    base    = n_wr2;
    pr_base = n_wr2;
    pr_data = 32'h4000_008D;
    begin
      int waited;
      waited = 0;
      while ((txd !== 1'b0) && (waited < 3000)) begin
        @(negedge CLOCK);
        waited++;
      end
    end
    check("rt_start_seen", {31'b0, txd}, 32'd0);
    clocks(256 + 20);
    RESET = 1'b1;
    @(negedge CLOCK);
    check("rt_txd_high",  {31'b0, txd},         32'd1);
    check("rt_tx_idle",   {31'b0, dut.tx_busy}, 32'd0);
    clocks(3);
    RESET = 1'b0;
    check("rt_overrun",   {24'b0, overrun},     32'd0);
    check("rt_framerr",   {24'b0, framerr},     32'd0);
    check("rt_no_ack",    n_wr2,                base);
    capture_frame("rt", frame, slen, n2s);
    check("rt_start_len", slen,                 32'd64);
    check("rt_frame",     {22'b0, frame},       32'h31A);
    wait_wr2(base + 1);
    check("rt_ack_count", n_wr2,                base + 1);
    check("rt_ack_data",  last_wr2,             32'h8000_0000);
    check("rt_bad_addr",  n_wr_bad,             32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tty_uart_bridge.md
TTY_UART_BRIDGE -- requirements
Module: tty_uart_bridge

Interface
REQ-001 Parameter BAUDDIV, default 651, CLOCK cycles per 16x-oversample tick (100 MHz, 9600 baud).
REQ-002 Parameter ENABLE, default 1, value written to the teletype enable bit on every keyboard write.
REQ-003 CLOCK  in  1  system clock; all state changes on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 rxd  in  1  async serial input, 8N1, idle high.
REQ-006 txd  out  1  serial output, 8N1, idle high.
REQ-007 ttwrite  out  1  one-cycle write strobe to the teletype register port.
REQ-008 ttraddr  out  2  teletype read register select.
REQ-009 ttwaddr  out  2  teletype write register select.
REQ-010 ttwdata  out  32  teletype write data.
REQ-011 ttrdata  in  32  teletype read data, combinational from ttraddr.
REQ-012 overrun  out  8  saturating count of received bytes dropped because the holding register was full.
REQ-013 framerr  out  8  saturating count of bytes dropped for a bad stop bit.

Function
REQ-014 Tick generator: counter 0..BAUDDIV-1, one-cycle tick when it wraps; free-running.
REQ-015 rxd passes through a two-flop synchronizer before any use.
REQ-016 RX states: IDLE, START, DATA, STOP.
- IDLE->START on a synchronized low.
- START: after 8 ticks, resample; low -> DATA, high -> IDLE (glitch, no count).
- DATA: sample every 16 ticks; 8 bits, LSB first.
- STOP: sample after 16 ticks; high -> byte valid; low -> framerr+1, byte discarded; both -> IDLE.
REQ-017 A valid byte loads a 1-deep holding register (kbhold, kbfull=1); a valid byte arriving while kbfull=1 is dropped and increments overrun.
REQ-018 Poll engine states: POLLKB, POLLPR, TXWAIT, PRDONE; one register access per cycle; ttwrite high for at most one cycle per write.
REQ-019 POLLKB: ttraddr=1; if kbfull=1 and ttrdata[31]=0, then in the same cycle assert ttwrite, ttwaddr=1, ttwdata={1, ENABLE, 18'b0, 4'b0, kbhold}, clear kbfull; next state POLLPR.
REQ-020 POLLPR: ttraddr=2; if ttrdata[30]=1 (prfull) and TX idle, load TX shifter with ttrdata[7:0] and go to TXWAIT; else go to POLLKB.
REQ-021 TXWAIT: hold until TX returns to idle after the stop bit, then go to PRDONE.
REQ-022 PRDONE: assert ttwrite, ttwaddr=2, ttwdata={1, 0, 30'b0} (prflag=1, prfull=0); next state POLLKB.
REQ-023 While in TXWAIT, the engine alternates a POLLKB cycle each CLOCK, so keyboard delivery is not blocked by printing.
REQ-024 TX: each bit lasts exactly 16 ticks: start(0), 8 data bits LSB first, stop(1); txd is registered.
REQ-025 Counters saturate at 255 and do not wrap.
REQ-026 If kbfull is set and a new byte completes in the same cycle that POLLKB clears kbfull, the new byte is accepted into kbhold, kbfull stays 1, and overrun is not incremented.

Reset
REQ-027 RESET: txd=1, ttwrite=0, ttwaddr=0, ttraddr=1, ttwdata=0, kbfull=0, overrun=0, framerr=0, RX=IDLE, poll=POLLKB, TX idle, tick counter=0.
REQ-028 RESET asserted mid-frame aborts RX and TX immediately; txd returns high the next cycle; no teletype write is issued for an aborted character.

Verification
REQ-029 BAUDDIV=4, rxd frame 0x41 with ttrdata[31]=0 -> one ttwrite, ttwaddr=1, ttwdata=0xC0000041.
REQ-030 ttrdata on reg 2 = 0x4000008D -> txd frame 0,1,0,1,1,0,0,0,1,1, each bit 64 CLOCKs, followed by ttwrite, ttwaddr=2, ttwdata=0x80000000.
REQ-031 Three bytes received back to back with ttrdata[31] held 1 -> first byte held, overrun=2, no ttwrite to reg 1.
REQ-032 Frame with stop bit 0 -> framerr=1, kbfull stays 0.
REQ-033 A 2-tick low glitch on rxd -> no byte and no counter change.
REQ-034 RESET during TX data bit 3 -> txd=1 next cycle, no reg 2 write; the next prfull=1 poll retransmits from the start bit.
